// File: rtl/router_arp_rewrite_if.sv
// AXI4-Stream bundle used on both sides of the ARP rewrite stage.
interface router_arp_rewrite_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TSTRB;
  logic [TUSER_WIDTH-1:0]  TUSER;
  logic                    TVALID;
  logic                    TREADY;
  logic                    TLAST;

  modport master (output TDATA, TSTRB, TUSER, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TSTRB, TUSER, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/router_arp_rewrite.sv
// Next-hop ARP resolution and first-beat header rewrite. The first beat of
// each packet is held while the next hop is resolved; body beats then flow
// straight through.
module router_arp_rewrite #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_RESETN,
  router_arp_rewrite_if.slave   S_AXIS,
  router_arp_rewrite_if.master  M_AXIS,
  input  logic                  lpm_hit_in,
  input  logic [31:0]           nh_in,
  input  logic [31:0]           oq_in,
  input  logic                  arp_wr_en,
  input  logic [4:0]            arp_wr_addr,
  input  logic [31:0]           arp_wr_ip,
  input  logic [47:0]           arp_wr_mac,
  input  logic                  arp_wr_valid,
  output logic [31:0]           arp_miss_count,
  output logic [31:0]           lpm_miss_count,
  output logic [31:0]           ttl_exp_count
);

  localparam int S_STRB_WIDTH = C_S_AXIS_DATA_WIDTH / 8;
  localparam int M_STRB_WIDTH = C_M_AXIS_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, CAPTURE, LOOKUP, EMIT, PASS} state_t;

  state_t state, next_state;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  hdr_data;
  logic [S_STRB_WIDTH-1:0]         hdr_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] hdr_user;
  logic                            hdr_last;

  logic        lpm_hit_q;
  logic [31:0] nh_q;
  logic [31:0] oq_q;
  logic        is_bypass, is_non_ip, is_ttl_exp;

  logic [31:0] arp_ip  [32];
  logic [47:0] arp_mac [32];
  logic [31:0] arp_valid;

  logic        lookup_hit;
  logic [47:0] lookup_mac;
  logic        arp_hit_q;
  logic [47:0] mac_q;

  logic [C_M_AXIS_DATA_WIDTH-1:0]  emit_data;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] emit_user;
  logic [7:0]                      cpu_dst, fwd_dst;
  logic [16:0]                     csum_sum;
  logic [15:0]                     csum_new;

  // State register
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN)
    if (!AXI_RESETN) state <= IDLE;
    else             state <= next_state;

  // Capture the first beat of a packet while idle
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN)
    if (!AXI_RESETN) begin
      hdr_data <= '0;
      hdr_strb <= '0;
      hdr_user <= '0;
      hdr_last <= 1'b0;
    end else if (state == IDLE && S_AXIS.TVALID) begin
      hdr_data <= S_AXIS.TDATA;
      hdr_strb <= S_AXIS.TSTRB;
      hdr_user <= S_AXIS.TUSER;
      hdr_last <= S_AXIS.TLAST;
    end

  // Sample the LPM sideband one cycle after acceptance and classify the header
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN)
    if (!AXI_RESETN) begin
      lpm_hit_q  <= 1'b0;
      nh_q       <= '0;
      oq_q       <= '0;
      is_bypass  <= 1'b0;
      is_non_ip  <= 1'b0;
      is_ttl_exp <= 1'b0;
    end else if (state == CAPTURE) begin
      lpm_hit_q  <= lpm_hit_in;
      nh_q       <= nh_in;
      oq_q       <= oq_in;
      is_bypass  <= hdr_user[DST_PORT_POS+1] | hdr_user[DST_PORT_POS+3] |
                    hdr_user[DST_PORT_POS+5] | hdr_user[DST_PORT_POS+7];
      is_non_ip  <= (hdr_data[159:144] != 16'h0800) || hdr_last;
      is_ttl_exp <= (hdr_data[79:72] <= 8'd1);
    end

  // ARP table write port; a write lands on the edge after the strobe
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN)
    if (!AXI_RESETN) begin
      arp_valid <= '0;
      for (int i = 0; i < 32; i++) begin
        arp_ip[i]  <= '0;
        arp_mac[i] <= '0;
      end
    end else if (arp_wr_en) begin
      arp_ip[arp_wr_addr]    <= arp_wr_ip;
      arp_mac[arp_wr_addr]   <= arp_wr_mac;
      arp_valid[arp_wr_addr] <= arp_wr_valid;
    end

  // Parallel ARP match; scanning downwards lets the lowest index win
  always_comb begin
    lookup_hit = 1'b0;
    lookup_mac = '0;
    for (int i = 31; i >= 0; i--) begin
      if (arp_valid[i] && arp_ip[i] == nh_q) begin
        lookup_hit = 1'b1;
        lookup_mac = arp_mac[i];
      end
    end
  end

  // Latch the lookup result and bump the one event counter the packet earns
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN)
    if (!AXI_RESETN) begin
      arp_hit_q      <= 1'b0;
      mac_q          <= '0;
      arp_miss_count <= '0;
      lpm_miss_count <= '0;
      ttl_exp_count  <= '0;
    end else if (state == LOOKUP) begin
      arp_hit_q <= lookup_hit;
      mac_q     <= lookup_mac;
      if (!is_bypass && !is_non_ip) begin
        if (!lpm_hit_q)
          lpm_miss_count <= lpm_miss_count + 32'd1;
        else if (is_ttl_exp)
          ttl_exp_count <= ttl_exp_count + 32'd1;
        else if (oq_q <= 32'd3 && !lookup_hit)
          arp_miss_count <= arp_miss_count + 32'd1;
      end
    end

  // Build the rewritten first beat from the held header and lookup result
  always_comb begin
    cpu_dst = '0;
    for (int k = 0; k < 4; k++)
      cpu_dst[2*k+1] = hdr_user[SRC_PORT_POS+2*k];
    fwd_dst   = 8'd1 << {oq_q[1:0], 1'b0};
    csum_sum  = {1'b0, hdr_data[63:48]} + 17'h00100;
    csum_new  = csum_sum[15:0] + {15'd0, csum_sum[16]};
    emit_data = hdr_data;
    emit_user = hdr_user;
    if (!is_bypass) begin
      if (is_non_ip || !lpm_hit_q || is_ttl_exp || oq_q > 32'd3 || !arp_hit_q) begin
        emit_user[DST_PORT_POS+7:DST_PORT_POS] = cpu_dst;
      end else begin
        emit_data[255:208] = mac_q;
        emit_data[79:72]   = hdr_data[79:72] - 8'd1;
        emit_data[63:48]   = csum_new;
        emit_user[DST_PORT_POS+7:DST_PORT_POS] = fwd_dst;
      end
    end
  end

  // Next-state and stream outputs; body beats pass through combinationally
  always_comb begin
    next_state    = state;
    S_AXIS.TREADY = 1'b0;
    M_AXIS.TVALID = 1'b0;
    M_AXIS.TDATA  = '0;
    M_AXIS.TSTRB  = '0;
    M_AXIS.TUSER  = '0;
    M_AXIS.TLAST  = 1'b0;
    case (state)
      IDLE: begin
        S_AXIS.TREADY = 1'b1;
        if (S_AXIS.TVALID) next_state = CAPTURE;
      end
      CAPTURE: next_state = LOOKUP;
      LOOKUP:  next_state = EMIT;
      EMIT: begin
        M_AXIS.TVALID = 1'b1;
        M_AXIS.TDATA  = emit_data;
        M_AXIS.TSTRB  = M_STRB_WIDTH'(hdr_strb);
        M_AXIS.TUSER  = emit_user;
        M_AXIS.TLAST  = hdr_last;
        if (M_AXIS.TREADY) next_state = hdr_last ? IDLE : PASS;
      end
      PASS: begin
        M_AXIS.TVALID = S_AXIS.TVALID;
        M_AXIS.TDATA  = S_AXIS.TDATA;
        M_AXIS.TSTRB  = S_AXIS.TSTRB;
        M_AXIS.TUSER  = S_AXIS.TUSER;
        M_AXIS.TLAST  = S_AXIS.TLAST;
        S_AXIS.TREADY = M_AXIS.TREADY;
        if (S_AXIS.TVALID && M_AXIS.TREADY && S_AXIS.TLAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_router_arp_rewrite.sv
// Bench for router_arp_rewrite: directed packets against a behavioural
// model of the rewrite rules plus hand-computed literal expectations.
module tb_router_arp_rewrite;

  localparam int SRC = 16;
  localparam int DST = 24;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        lpm_hit;
  logic [31:0] nh, oq;
  logic        arp_wr_en;
  logic [4:0]  arp_wr_addr;
  logic [31:0] arp_wr_ip;
  logic [47:0] arp_wr_mac;
  logic        arp_wr_valid;
  logic [31:0] arp_miss_count, lpm_miss_count, ttl_exp_count;

  router_arp_rewrite_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if ();
  router_arp_rewrite_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) m_if ();

  router_arp_rewrite dut (
    .AXI_ACLK      (clk),
    .AXI_RESETN    (rst_n),
    .S_AXIS        (s_if.slave),
    .M_AXIS        (m_if.master),
    .lpm_hit_in    (lpm_hit),
    .nh_in         (nh),
    .oq_in         (oq),
    .arp_wr_en     (arp_wr_en),
    .arp_wr_addr   (arp_wr_addr),
    .arp_wr_ip     (arp_wr_ip),
    .arp_wr_mac    (arp_wr_mac),
    .arp_wr_valid  (arp_wr_valid),
    .arp_miss_count(arp_miss_count),
    .lpm_miss_count(lpm_miss_count),
    .ttl_exp_count (ttl_exp_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;
  int first_valid_cyc = -1;
  int accept_cyc = 0;
  int beats_seen = 0;
  bit in_pkt = 0;
  beat_t exp_q[$];
  beat_t got_first;

  logic [31:0] m_ip  [32];
  logic [47:0] m_mac [32];
  logic        m_vld [32];
  int unsigned exp_lpm = 0, exp_ttl = 0, exp_arp = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always, alternating, or held off
  initial begin
    m_if.TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_if.TREADY = 1'b1;
        1:       m_if.TREADY = ~m_if.TREADY;
        default: m_if.TREADY = 1'b0;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Every accepted output beat must be the next one the model predicted
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && m_if.TVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rst_n && m_if.TVALID && m_if.TREADY) begin
        beats_seen++;
        if (!in_pkt) begin
          got_first.data = m_if.TDATA;
          got_first.strb = m_if.TSTRB;
          got_first.user = m_if.TUSER;
          got_first.last = m_if.TLAST;
        end
        in_pkt = !m_if.TLAST;
        if (exp_q.size() == 0) begin
          check_output("beat_pending", 256'(exp_q.size()), 256'(1));
        end else begin
          e = exp_q.pop_front();
          check_output("beat_tdata", m_if.TDATA, e.data);
          check_output("beat_tstrb", 256'(m_if.TSTRB), 256'(e.strb));
          check_output("beat_tuser", 256'(m_if.TUSER), 256'(e.user));
          check_output("beat_tlast", 256'(m_if.TLAST), 256'(e.last));
        end
      end
    end
  end

  // Expected first beat from the forwarding rules and the shadow ARP table
  function automatic beat_t predict_first(input beat_t b, input logic hit, input logic [31:0] nh_v, input logic [31:0] oq_v);
    beat_t r;
    logic [7:0]  dst_byte, src_byte, cpu_byte;
    logic        found;
    logic [47:0] mac;
    int          s;
    r = b;
    dst_byte = b.user[DST+:8];
    src_byte = b.user[SRC+:8];
    cpu_byte = (src_byte & 8'h55) << 1;
    found = 1'b0;
    mac = '0;
    for (int i = 0; i < 32; i++)
      if (!found && m_vld[i] && m_ip[i] == nh_v) begin
        found = 1'b1;
        mac = m_mac[i];
      end
    if ((dst_byte & 8'hAA) != 8'h00) return r;
    if (b.data[159:144] != 16'h0800 || b.last) begin
      r.user[DST+:8] = cpu_byte;
      return r;
    end
    if (!hit) begin
      exp_lpm++;
      r.user[DST+:8] = cpu_byte;
    end else if (b.data[79:72] <= 8'd1) begin
      exp_ttl++;
      r.user[DST+:8] = cpu_byte;
    end else if (oq_v > 32'd3) begin
      r.user[DST+:8] = cpu_byte;
    end else if (!found) begin
      exp_arp++;
      r.user[DST+:8] = cpu_byte;
    end else begin
      r.data[255:208] = mac;
      r.data[79:72] = b.data[79:72] - 8'd1;
      s = int'(b.data[63:48]) + 256;
      if (s > 65535) s = s - 65535;
      r.data[63:48] = s[15:0];
      r.user[DST+:8] = 8'(1 << (2 * oq_v));
    end
    return r;
  endfunction

  function automatic beat_t make_first(input logic [15:0] etype, input logic [7:0] ttl, input logic [15:0] csum,
                                       input logic [7:0] src, input logic [7:0] dst);
    beat_t b;
    for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = 32'h1357_9BD0 + 32'(w);
    b.data[255:208] = 48'hFFEE_DDCC_BBAA;
    b.data[159:144] = etype;
    b.data[79:72]   = ttl;
    b.data[63:48]   = csum;
    b.strb = '1;
    b.user = {64'hCAFE_F00D_0BAD_BEEF, 32'h0, dst, src, 16'h0040};
    b.last = 1'b0;
    return b;
  endfunction

  function automatic beat_t make_body(input logic last);
    beat_t b;
    for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom;
    b.strb = $urandom;
    b.user = {$urandom, $urandom, $urandom, $urandom};
    b.last = last;
    return b;
  endfunction

  task automatic send_beat(input beat_t b, input bit is_first);
    int waited = 0;
    s_if.TDATA  = b.data;
    s_if.TSTRB  = b.strb;
    s_if.TUSER  = b.user;
    s_if.TLAST  = b.last;
    s_if.TVALID = 1'b1;
    forever begin
      @(negedge clk);
      if (s_if.TREADY) break;
      waited++;
      if (waited > 200) begin
        check_output("s_ready_timeout", 256'(0), 256'(1));
        break;
      end
    end
    if (is_first) accept_cyc = cyc;
    @(posedge clk);
    #1;
    s_if.TVALID = 1'b0;
  endtask

  task automatic apply_stimulus(input beat_t first, input int n_body, input logic hit,
                                input logic [31:0] nh_v, input logic [31:0] oq_v);
    beat_t f, b;
    beat_t body[$];
    f = first;
    f.last = (n_body == 0);
    lpm_hit = hit;
    nh = nh_v;
    oq = oq_v;
    first_valid_cyc = -1;
    exp_q.push_back(predict_first(f, hit, nh_v, oq_v));
    for (int i = 0; i < n_body; i++) begin
      b = make_body(i == n_body - 1);
      body.push_back(b);
      exp_q.push_back(b);
    end
    send_beat(f, 1'b1);
    foreach (body[i]) send_beat(body[i], 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #1;
    check_output("drain", 256'(exp_q.size()), 256'(0));
    exp_q.delete();
    check_output("tvalid_latency", 256'(first_valid_cyc - accept_cyc), 256'(3));
    check_output("lpm_miss_count", 256'(lpm_miss_count), 256'(exp_lpm));
    check_output("ttl_exp_count", 256'(ttl_exp_count), 256'(exp_ttl));
    check_output("arp_miss_count", 256'(arp_miss_count), 256'(exp_arp));
  endtask

  task automatic arp_write(input int addr, input logic [31:0] ip, input logic [47:0] mac, input logic v);
    @(posedge clk);
    #1;
    arp_wr_en = 1'b1;
    arp_wr_addr = 5'(addr);
    arp_wr_ip = ip;
    arp_wr_mac = mac;
    arp_wr_valid = v;
    @(posedge clk);
    #1;
    arp_wr_en = 1'b0;
    m_ip[addr] = ip;
    m_mac[addr] = mac;
    m_vld[addr] = v;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    beat_t p, b1, b2;
    for (int i = 0; i < 32; i++) begin
      m_ip[i] = '0;
      m_mac[i] = '0;
      m_vld[i] = 1'b0;
    end
    s_if.TVALID = 1'b0;
    s_if.TDATA = '0;
    s_if.TSTRB = '0;
    s_if.TUSER = '0;
    s_if.TLAST = 1'b0;
    lpm_hit = 1'b0;
    nh = '0;
    oq = '0;
    arp_wr_en = 1'b0;
    arp_wr_addr = '0;
    arp_wr_ip = '0;
    arp_wr_mac = '0;
    arp_wr_valid = 1'b0;

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    check_output("rst_m_tvalid", 256'(m_if.TVALID), 256'(0));
    check_output("rst_m_tdata", m_if.TDATA, 256'(0));
    check_output("rst_m_tuser", 256'(m_if.TUSER), 256'(0));
    check_output("rst_m_tstrb", 256'(m_if.TSTRB), 256'(0));
    check_output("rst_m_tlast", 256'(m_if.TLAST), 256'(0));
    check_output("rst_counters", 256'({lpm_miss_count, ttl_exp_count, arp_miss_count}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_s_tready", 256'(s_if.TREADY), 256'(1));

    // Forwarded packet through ARP[3]
    arp_write(3, 32'h0A00_0002, 48'h0011_2233_4455, 1'b1);
    p = make_first(16'h0800, 8'd64, 16'hB1E6, 8'h01, 8'h00);
    apply_stimulus(p, 1, 1'b1, 32'h0A00_0002, 32'd2);
    wait_drain();
    check_output("fwd_da", 256'(got_first.data[255:208]), 256'(48'h0011_2233_4455));
    check_output("fwd_ttl", 256'(got_first.data[79:72]), 256'(8'd63));
    check_output("fwd_csum", 256'(got_first.data[63:48]), 256'(16'hB2E6));
    check_output("fwd_dst", 256'(got_first.user[DST+:8]), 256'(8'h10));
    check_output("fwd_latency", 256'(first_valid_cyc - accept_cyc), 256'(3));

    // Checksum end-around carry
    p = make_first(16'h0800, 8'd64, 16'hFF00, 8'h01, 8'h00);
    apply_stimulus(p, 2, 1'b1, 32'h0A00_0002, 32'd2);
    wait_drain();
    check_output("csum_wrap", 256'(got_first.data[63:48]), 256'(16'h0001));

    // ARP miss from source port 2
    p = make_first(16'h0800, 8'd64, 16'h1234, 8'h10, 8'h00);
    apply_stimulus(p, 1, 1'b1, 32'h0A00_0063, 32'd0);
    wait_drain();
    check_output("miss_dst", 256'(got_first.user[DST+:8]), 256'(8'h20));
    check_output("miss_data", got_first.data, p.data);
    check_output("miss_count", 256'(arp_miss_count), 256'(1));

    // TTL=1 with LPM miss, then with LPM hit
    p = make_first(16'h0800, 8'd1, 16'h4321, 8'h01, 8'h00);
    apply_stimulus(p, 1, 1'b0, 32'h0A00_0002, 32'd2);
    wait_drain();
    check_output("ttl_lpm_counts", 256'({lpm_miss_count, ttl_exp_count}), 256'({32'd1, 32'd0}));
    check_output("ttl_lpm_dst", 256'(got_first.user[DST+:8]), 256'(8'h02));
    apply_stimulus(p, 1, 1'b1, 32'h0A00_0002, 32'd2);
    wait_drain();
    check_output("ttl_exp_counts", 256'({lpm_miss_count, ttl_exp_count}), 256'({32'd1, 32'd1}));

    // Out-of-range queue, non-IP ethertype, single-beat IP packet
    p = make_first(16'h0800, 8'd64, 16'h0F0F, 8'h04, 8'h00);
    apply_stimulus(p, 1, 1'b1, 32'h0A00_0002, 32'd5);
    wait_drain();
    check_output("oq_bad_dst", 256'(got_first.user[DST+:8]), 256'(8'h08));
    p = make_first(16'h86DD, 8'd64, 16'h0F0F, 8'h40, 8'h00);
    apply_stimulus(p, 2, 1'b1, 32'h0A00_0002, 32'd1);
    wait_drain();
    p = make_first(16'h0800, 8'd64, 16'h0F0F, 8'h01, 8'h00);
    apply_stimulus(p, 0, 1'b1, 32'h0A00_0002, 32'd1);
    wait_drain();

    // Bypass packet under alternating downstream ready
    ready_mode = 1;
    beats_seen = 0;
    p = make_first(16'h0800, 8'd64, 16'hB1E6, 8'h01, 8'h02);
    apply_stimulus(p, 2, 1'b1, 32'h0A00_0002, 32'd2);
    wait_drain();
    ready_mode = 0;
    check_output("bypass_beats", 256'(beats_seen), 256'(3));
    check_output("bypass_data", got_first.data, p.data);
    check_output("bypass_user", 256'(got_first.user), 256'(p.user));

    // Duplicate IP: lowest index wins
    arp_write(5, 32'h0A00_0005, 48'hAAAA_AAAA_AA05, 1'b1);
    arp_write(9, 32'h0A00_0005, 48'hBBBB_BBBB_BB09, 1'b1);
    p = make_first(16'h0800, 8'd32, 16'h2222, 8'h01, 8'h00);
    apply_stimulus(p, 1, 1'b1, 32'h0A00_0005, 32'd1);
    wait_drain();
    check_output("dup_da", 256'(got_first.data[255:208]), 256'(48'hAAAA_AAAA_AA05));
    check_output("dup_dst", 256'(got_first.user[DST+:8]), 256'(8'h04));

    // ARP write landing in the lookup cycle is not seen by that lookup
    fork
      apply_stimulus(p, 1, 1'b1, 32'h0A00_0005, 32'd1);
      begin
        int n = 0;
        forever begin
          @(negedge clk);
          if (s_if.TVALID && s_if.TREADY) break;
          n++;
          if (n > 50) begin
            check_output("lookup_wr_timeout", 256'(0), 256'(1));
            break;
          end
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        arp_wr_en = 1'b1;
        arp_wr_addr = 5'd5;
        arp_wr_ip = 32'h0A00_0005;
        arp_wr_mac = 48'hCCCC_CCCC_CC05;
        arp_wr_valid = 1'b1;
        @(posedge clk);
        #1;
        arp_wr_en = 1'b0;
        m_mac[5] = 48'hCCCC_CCCC_CC05;
      end
    join
    wait_drain();
    check_output("lookup_wr_old_da", 256'(got_first.data[255:208]), 256'(48'hAAAA_AAAA_AA05));
    apply_stimulus(p, 1, 1'b1, 32'h0A00_0005, 32'd1);
    wait_drain();
    check_output("lookup_wr_new_da", 256'(got_first.data[255:208]), 256'(48'hCCCC_CCCC_CC05));

    // Reset asserted while body beats are passing through
    p = make_first(16'h0800, 8'd64, 16'hB1E6, 8'h01, 8'h00);
    lpm_hit = 1'b1;
    nh = 32'h0A00_0002;
    oq = 32'd2;
    b1 = make_body(1'b0);
    b2 = make_body(1'b1);
    exp_q.push_back(predict_first(p, 1'b1, nh, oq));
    exp_q.push_back(b1);
    send_beat(p, 1'b1);
    send_beat(b1, 1'b0);
    ready_mode = 2;
    @(posedge clk);
    #2;
    s_if.TDATA = b2.data;
    s_if.TSTRB = b2.strb;
    s_if.TUSER = b2.user;
    s_if.TLAST = b2.last;
    s_if.TVALID = 1'b1;
    @(negedge clk);
    check_output("pass_consumed", 256'(exp_q.size()), 256'(0));
    check_output("pass_tvalid", 256'(m_if.TVALID), 256'(1));
    check_output("pass_tdata", m_if.TDATA, b2.data);
    check_output("pass_stall", 256'(s_if.TREADY), 256'(0));
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_tvalid", 256'(m_if.TVALID), 256'(0));
    check_output("async_rst_tdata", m_if.TDATA, 256'(0));
    check_output("async_rst_tuser", 256'(m_if.TUSER), 256'(0));
    check_output("async_rst_tstrb", 256'(m_if.TSTRB), 256'(0));
    check_output("async_rst_tlast", 256'(m_if.TLAST), 256'(0));
    s_if.TVALID = 1'b0;
    exp_q.delete();
    in_pkt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    exp_lpm = 0;
    exp_ttl = 0;
    exp_arp = 0;
    for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
    @(negedge clk);
    check_output("post_rst_tready", 256'(s_if.TREADY), 256'(1));
    check_output("post_rst_counters", 256'({lpm_miss_count, ttl_exp_count, arp_miss_count}), 256'(0));

    // Normal forwarding after reset release
    arp_write(3, 32'h0A00_0002, 48'h0011_2233_4455, 1'b1);
    p = make_first(16'h0800, 8'd64, 16'hB1E6, 8'h01, 8'h00);
    apply_stimulus(p, 2, 1'b1, 32'h0A00_0002, 32'd3);
    wait_drain();
    check_output("post_rst_da", 256'(got_first.data[255:208]), 256'(48'h0011_2233_4455));
    check_output("post_rst_dst", 256'(got_first.user[DST+:8]), 256'(8'h40));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
